fir_config_loader: RTL and testbench
====================================

// Module: fir_config_loader
// PURPOSE
//  Transmit side of the FIR coefficient-configuration interface.
//  Snapshots a parallel coefficient set plus tap count on start, then drives the
//  serial byte-shift protocol (cfg_enable level, one-cycle cfg_data_enable strobes,
//  cfg_data valid in the strobe cycle) into the filter's configuration block.
//  Sits between the host/register bank and the filter datapath configuration port.
// PARAMETERS
//  NUM_COEF   16  coefficients per frame; frame length = NUM_COEF+1 bytes
//  COEF_W     8   coefficient / byte width
//  SETUP_CYC  1   cycles cfg_enable is high before first strobe (>=1)
//  GAP_CYC    0   idle cycles between consecutive strobes (>=0)
//  HOLD_CYC   1   cycles cfg_enable stays high after last strobe (>=1)
// PORTS
//  clk              in   1                  clock, rising edge
//  rst_n            in   1                  reset, synchronous, active-low
//  start            in   1                  request load; sampled in IDLE only
//  abort            in   1                  cancel an in-progress load
//  coef_in          in   NUM_COEF*COEF_W    coef k at bits [k*COEF_W +: COEF_W]
//  tap_num_in       in   4                  tap count field (taps-1)
//  cfg_enable       out  1                  configuration-mode level to receiver
//  cfg_data_enable  out  1                  one-cycle byte strobe
//  cfg_data         out  COEF_W             byte, valid only while strobe high
//  busy             out  1                  high from start accept to frame end
//  done             out  1                  one-cycle pulse on successful completion
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, snapshot cleared. Reset mid-load
//    drops cfg_enable next edge; no done.
//  - States: IDLE -> SETUP -> SEND <-> GAP -> HOLD -> IDLE.
//  - IDLE: start=1 at edge T0 latches {tap_num_in, coef_in}, busy=1 from T0+1.
//  - SETUP: cfg_enable=1 from T0+1; SETUP_CYC cycles, strobe low.
//  - SEND: one cycle, cfg_data_enable=1, cfg_data=current byte; byte counter++.
//    GAP_CYC=0 -> strobes on consecutive cycles; else GAP state for GAP_CYC cycles.
//  - Byte order (receiver is a shift chain, first byte lands deepest):
//    byte0 = {4'h0, tap_num}, byte1 = coef[NUM_COEF-1], ..., byteN = coef[0].
//  - First strobe at T0+1+SETUP_CYC; strobe i at that +i*(GAP_CYC+1).
//  - After byte NUM_COEF: HOLD for HOLD_CYC cycles with cfg_enable=1, strobe low.
//    Next cycle: IDLE, cfg_enable=0, busy=0, done=1 (single cycle).
//  - start in the done cycle is accepted (back-to-back frames allowed).
//  - start while busy: ignored, snapshot unchanged.
//  - abort while busy (any non-IDLE state): next edge -> IDLE, cfg_enable=0,
//    strobe=0, busy=0, done stays 0. Receiver keeps partial shift; caller reloads.
//  - abort and start same cycle in IDLE: abort wins, start ignored.
//  - cfg_data = 0 whenever cfg_data_enable=0.
//  - Total cycles cfg_enable high = SETUP_CYC + (NUM_COEF+1) + NUM_COEF*GAP_CYC + HOLD_CYC.
//  - Byte counter width clog2(NUM_COEF+1); wait counter width covers
//    max(SETUP_CYC,GAP_CYC,HOLD_CYC); both saturate-free, reload on state entry.
// STRUCTURE
//  - Package fir_cfg_pkg: NUM_COEF, COEF_W, TAP_W=4, FRAME_LEN=NUM_COEF+1,
//    FSM state encoding (shared with the receiving config block's tests).
//  - Sub-module fir_cfg_frame_shifter: (NUM_COEF+1)*COEF_W load/shift register,
//    parallel load on accept, shift one byte per strobe, head byte = cfg_data.
//  - Top: FSM + wait counter + byte counter + output registers (all outputs registered).
// TESTING
//  - Reset: hold rst_n=0 3 cycles -> all outputs 0; release, no start -> stays idle.
//  - Basic load, defaults, coef[k]=k+1, tap=9: strobes on 17 consecutive cycles,
//    data 09,10,0F,...,01; receiver model ends h_k=k+1, tap_num=9; done 1 cycle.
//  - GAP_CYC=2: strobes exactly 3 cycles apart, first at T0+2; total cfg_enable
//    high = 1+17+32+1 = 51 cycles; done after.
//  - start pulsed at strobe 5 and inputs changed -> ignored, original bytes sent.
//  - abort at strobe 5 -> cfg_enable=0 next cycle, no done; immediate restart
//    then completes with correct 17-byte frame.
//  - rst_n low during strobe 8 -> outputs 0 next edge; start after release
//    produces full correct frame; start in done cycle starts second frame.

Source files
------------

// File: rtl/fir_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_cfg_pkg
// Purpose  : Shared constants and FSM encoding for the FIR coefficient
//            configuration interface (loader and receiving config block).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fir_cfg_pkg;

  localparam int NUM_COEF  = 16;            // coefficients per frame
  localparam int COEF_W    = 8;             // coefficient / byte width
  localparam int TAP_W     = 4;             // tap count field width
  localparam int FRAME_LEN = NUM_COEF + 1;  // bytes per frame (tap byte + coefs)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4
  } cfg_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_config_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_config_loader_if
// Purpose  : Serial byte-shift configuration bus between the coefficient
//            loader (master) and the filter configuration block (slave).
// Signals  : cfg_enable      - configuration-mode level
//            cfg_data_enable - one-cycle byte strobe
//            cfg_data        - byte, meaningful only while strobe is high
// Revision : 1.0 - initial release
// ============================================================================
interface fir_config_loader_if #(
  parameter int COEF_W = 8
);
  logic              cfg_enable;
  logic              cfg_data_enable;
  logic [COEF_W-1:0] cfg_data;

  modport master (output cfg_enable, output cfg_data_enable, output cfg_data);
  modport slave  (input  cfg_enable, input  cfg_data_enable, input  cfg_data);
endinterface
`default_nettype wire

// File: rtl/fir_cfg_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module   : fir_cfg_frame_shifter
// Purpose  : Frame snapshot register. Parallel load of a whole frame, then
//            pops one byte per shift; the head byte is the next to transmit.
// Ports    : clk, rst_n     - clock, synchronous active-low reset
//            load          - capture load_data (byte 0 in the MSBs)
//            load_data     - NUM_BYTES*BYTE_W frame image
//            shift         - drop the head byte, move the next one up
//            head          - current head byte
// Revision : 1.0 - initial release
// ============================================================================
module fir_cfg_frame_shifter #(
  parameter int NUM_BYTES = 17,
  parameter int BYTE_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [NUM_BYTES*BYTE_W-1:0]   load_data,
  input  logic                          shift,
  output logic [BYTE_W-1:0]             head
);
  localparam int FRAME_W = NUM_BYTES * BYTE_W;

  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (load) begin
      frame_d = load_data;
    end else if (shift) begin
      frame_d = {frame_q[FRAME_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign head = frame_q[FRAME_W-1 -: BYTE_W];

endmodule
`default_nettype wire

// File: rtl/fir_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_config_loader
// Purpose  : Transmit side of the FIR coefficient configuration interface.
//            Snapshots coefficients + tap count on start, then shifts the
//            frame out as strobed bytes framed by the cfg_enable level.
// Ports    : clk, rst_n     - clock, synchronous active-low reset
//            start         - load request, honoured in IDLE only
//            abort         - cancel an in-progress load (wins over start)
//            coef_in       - coef k at [k*COEF_W +: COEF_W]
//            tap_num_in    - tap count field (taps-1)
//            busy          - high from start accept until frame end
//            done          - one-cycle pulse on successful completion
//            cfg           - configuration bus (master side)
// Revision : 1.0 - initial release
// ============================================================================
module fir_config_loader
  import fir_cfg_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int GAP_CYC   = 0,
  parameter int HOLD_CYC  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_COEF*COEF_W-1:0]  coef_in,
  input  logic [TAP_W-1:0]            tap_num_in,
  output logic                        busy,
  output logic                        done,
  fir_config_loader_if.master         cfg
);
  localparam int MAX_WAIT   = max3(SETUP_CYC, GAP_CYC, HOLD_CYC);
  // Counter holds "cycles remaining minus one", so MAX_WAIT-1 is the top value.
  localparam int WAIT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int BYTE_CNT_W = $clog2(FRAME_LEN);

  localparam logic [WAIT_W-1:0]     SETUP_LD  = WAIT_W'(SETUP_CYC - 1);
  localparam logic [WAIT_W-1:0]     GAP_LD    = WAIT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [WAIT_W-1:0]     HOLD_LD   = WAIT_W'(HOLD_CYC - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(FRAME_LEN - 1);

  cfg_state_e              state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                    accept;
  logic                    shift_en;
  logic [COEF_W-1:0]       head;

  logic                    cfg_enable_q, cfg_enable_d;
  logic                    cfg_data_enable_q, cfg_data_enable_d;
  logic [COEF_W-1:0]       cfg_data_q, cfg_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Byte 0 (tap byte) sits in the MSBs, followed by coef[NUM_COEF-1] .. coef[0],
  // which is exactly the order coef_in already has from its top down.
  fir_cfg_frame_shifter #(
    .NUM_BYTES (FRAME_LEN),
    .BYTE_W    (COEF_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data ({{(COEF_W-TAP_W){1'b0}}, tap_num_in, coef_in}),
    .shift     (shift_en),
    .head      (head)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Next-state logic. shift_en marks every entry into SEND: the head byte is
  // captured into cfg_data on that edge and popped from the shifter together.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    byte_cnt_d = byte_cnt_q;
    accept     = 1'b0;
    shift_en   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            accept     = 1'b1;
            state_d    = ST_SETUP;
            wait_d     = SETUP_LD;
            byte_cnt_d = '0;
          end
        end
        ST_SETUP: begin
          if (wait_q == '0) begin
            state_d  = ST_SEND;
            shift_en = 1'b1;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        ST_SEND: begin
          byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_HOLD;
            wait_d  = HOLD_LD;
          end else if (GAP_CYC == 0) begin
            state_d  = ST_SEND;
            shift_en = 1'b1;
          end else begin
            state_d = ST_GAP;
            wait_d  = GAP_LD;
          end
        end
        ST_GAP: begin
          if (wait_q == '0) begin
            state_d  = ST_SEND;
            shift_en = 1'b1;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        ST_HOLD: begin
          if (wait_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic, decoded from the next state so the registered outputs line
  // up with the state they describe.
  always_comb begin
    cfg_enable_d      = (state_d != ST_IDLE);
    busy_d            = (state_d != ST_IDLE);
    cfg_data_enable_d = (state_d == ST_SEND);
    cfg_data_d        = (state_d == ST_SEND) ? head : '0;
    done_d            = (state_q == ST_HOLD) && (state_d == ST_IDLE) && !abort;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_enable_q      <= 1'b0;
      cfg_data_enable_q <= 1'b0;
      cfg_data_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      cfg_enable_q      <= cfg_enable_d;
      cfg_data_enable_q <= cfg_data_enable_d;
      cfg_data_q        <= cfg_data_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

  assign cfg.cfg_enable      = cfg_enable_q;
  assign cfg.cfg_data_enable = cfg_data_enable_q;
  assign cfg.cfg_data        = cfg_data_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_config_loader
// Purpose  : Self-checking bench for fir_config_loader. dut_a uses default
//            timing, dut_b uses a 2-cycle inter-strobe gap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_config_loader;
  import fir_cfg_pkg::*;

  localparam int GAP_B = 2;
  localparam int CW    = NUM_COEF * COEF_W;

  typedef struct {
    logic [COEF_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start_a, abort_a, start_b, abort_b;
  logic [CW-1:0]    coef_in;
  logic [TAP_W-1:0] tap_num_in;
  logic             busy_a, done_a, busy_b, done_b;

  fir_config_loader_if #(.COEF_W(COEF_W)) cfg_a ();
  fir_config_loader_if #(.COEF_W(COEF_W)) cfg_b ();

  fir_config_loader #(.SETUP_CYC(1), .GAP_CYC(0), .HOLD_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .coef_in(coef_in), .tap_num_in(tap_num_in),
    .busy(busy_a), .done(done_a), .cfg(cfg_a)
  );

  fir_config_loader #(.SETUP_CYC(1), .GAP_CYC(GAP_B), .HOLD_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .coef_in(coef_in), .tap_num_in(tap_num_in),
    .busy(busy_b), .done(done_b), .cfg(cfg_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic [COEF_W-1:0] rx_a [FRAME_LEN];
  int   en_a = 0;
  int   en_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor A: scoreboard pop on every strobe, plus a receiver shift-chain model.
  always @(negedge clk) begin
    if (cfg_a.cfg_enable === 1'b1) en_a++;
    if (cfg_a.cfg_data_enable === 1'b1) begin
      for (int i = FRAME_LEN - 1; i > 0; i--) rx_a[i] = rx_a[i-1];
      rx_a[0] = cfg_a.cfg_data;
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_strobe: got data %0h at cycle %0d, required no strobe",
                 cfg_a.cfg_data, cyc);
      end else begin
        e_a = q_a.pop_front();
        chk("a_byte", cfg_a.cfg_data, e_a.data);
        chk("a_strobe_cycle", cyc, e_a.cyc);
        chk("a_enable_during_strobe", cfg_a.cfg_enable, 1);
      end
    end else if (cfg_a.cfg_enable === 1'b1) begin
      chk("a_data_zero_without_strobe", cfg_a.cfg_data, 0);
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (cfg_b.cfg_enable === 1'b1) en_b++;
    if (cfg_b.cfg_data_enable === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_strobe: got data %0h at cycle %0d, required no strobe",
                 cfg_b.cfg_data, cyc);
      end else begin
        e_b = q_b.pop_front();
        chk("b_byte", cfg_b.cfg_data, e_b.data);
        chk("b_strobe_cycle", cyc, e_b.cyc);
      end
    end else if (cfg_b.cfg_enable === 1'b1) begin
      chk("b_data_zero_without_strobe", cfg_b.cfg_data, 0);
    end
  end

  function automatic logic [CW-1:0] mk_pat(input int base, input int step);
    logic [CW-1:0] p;
    for (int k = 0; k < NUM_COEF; k++) p[k*COEF_W +: COEF_W] = COEF_W'(base + k*step);
    return p;
  endfunction

  // Expected frame: tap byte, then coef[NUM_COEF-1] down to coef[0];
  // first strobe two cycles after the cycle start is driven (SETUP_CYC=1).
  task automatic push_frame(input int d, input logic [CW-1:0] cv, input logic [TAP_W-1:0] tv,
                            input int cs, input int gap);
    exp_t e;
    for (int i = 0; i < FRAME_LEN; i++) begin
      e.data = (i == 0) ? {4'h0, tv} : cv[(NUM_COEF-i)*COEF_W +: COEF_W];
      e.cyc  = cs + 2 + i*(gap + 1);
      if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    end
  endtask

  // Called at a falling edge; returns one falling edge later.
  task automatic start_frame(input int d, input logic [CW-1:0] cv, input logic [TAP_W-1:0] tv,
                             output int cs);
    coef_in    = cv;
    tap_num_in = tv;
    cs         = cyc;
    if (d == 0) begin start_a = 1'b1; en_a = 0; end
    else        begin start_b = 1'b1; en_b = 0; end
    push_frame(d, cv, tv, cs, (d == 0) ? 0 : GAP_B);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int d, input int cs, input int gap);
    int exp_en;
    bit seen;
    seen   = 1'b0;
    exp_en = 1 + FRAME_LEN + NUM_COEF*gap + 1;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (((d == 0) ? done_a : done_b) === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within 300 cycles, required done (dut %0d)", d);
    end else begin
      chk("done_cycle", cyc, cs + 1 + exp_en);
      chk("enable_high_cycles", (d == 0) ? en_a : en_b, exp_en);
      chk("busy_low_at_done", (d == 0) ? busy_a : busy_b, 0);
      chk("enable_low_at_done", (d == 0) ? cfg_a.cfg_enable : cfg_b.cfg_enable, 0);
      chk("all_bytes_sent", (d == 0) ? q_a.size() : q_b.size(), 0);
    end
  endtask

  task automatic wait_strobes_a(input int n);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 100 && cnt < n; k++) begin
      @(negedge clk);
      if (cfg_a.cfg_data_enable === 1'b1) cnt++;
    end
    if (cnt < n) begin
      checks++; errors++;
      $display("FAIL strobe_timeout: got %0d strobes, required %0d", cnt, n);
    end
  endtask

  initial begin
    int            cs;
    logic [CW-1:0] cp;

    rst_n      = 1'b0;
    start_a    = 1'b0; abort_a = 1'b0;
    start_b    = 1'b0; abort_b = 1'b0;
    coef_in    = '0;
    tap_num_in = '0;
    for (int i = 0; i < FRAME_LEN; i++) rx_a[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_enable", cfg_a.cfg_enable, 0);
    chk("rst_strobe", cfg_a.cfg_data_enable, 0);
    chk("rst_data", cfg_a.cfg_data, 0);
    chk("rst_b_enable", cfg_b.cfg_enable, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy_a, 0);
    chk("idle_enable", cfg_a.cfg_enable, 0);
    chk("idle_b_busy", busy_b, 0);

    // Basic frame: coef[k]=k+1, tap=9
    start_frame(0, mk_pat(1, 1), 4'h9, cs);
    wait_done(0, cs, 0);
    for (int k = 0; k < NUM_COEF; k++) chk("rx_coef", rx_a[k], k + 1);
    chk("rx_tap", rx_a[NUM_COEF], 32'h09);
    @(negedge clk);
    chk("done_single_cycle", done_a, 0);

    // Gapped frame on dut_b
    start_frame(1, mk_pat(8'hA0, 1), 4'hF, cs);
    wait_done(1, cs, GAP_B);

    // start while busy with changed inputs: ignored
    @(negedge clk);
    cp = mk_pat(8'h5A, 7);
    start_frame(0, cp, 4'h3, cs);
    wait_strobes_a(6);
    start_a    = 1'b1;
    coef_in    = ~cp;
    tap_num_in = 4'h5;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, cs, 0);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    abort_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0; start_a = 1'b0;
    chk("abort_start_idle_busy", busy_a, 0);
    chk("abort_start_idle_enable", cfg_a.cfg_enable, 0);

    // abort at strobe 5, then immediate restart
    start_frame(0, mk_pat(8'hF0, 8'hFD), 4'h7, cs);
    wait_strobes_a(6);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_enable", cfg_a.cfg_enable, 0);
    chk("abort_strobe", cfg_a.cfg_data_enable, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_bytes_left", q_a.size(), 11);
    q_a.delete();
    start_frame(0, mk_pat(8'h11, 8'h11), 4'h2, cs);
    wait_done(0, cs, 0);

    // reset during strobe 8, restart, then back-to-back frame from done cycle
    @(negedge clk);
    start_frame(0, mk_pat(8'h80, 3), 4'h1, cs);
    wait_strobes_a(9);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_enable", cfg_a.cfg_enable, 0);
    chk("midrst_strobe", cfg_a.cfg_data_enable, 0);
    chk("midrst_data", cfg_a.cfg_data, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_bytes_left", q_a.size(), 8);
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_frame(0, mk_pat(8'h3C, 5), 4'hA, cs);
    wait_done(0, cs, 0);
    start_frame(0, mk_pat(8'hC3, 9), 4'hC, cs);
    wait_done(0, cs, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
